dec_scan_nch: RTL and testbench

Parametrised, registered successor to the dual 2-to-4 decoder. Provides NCH independent active-low SEL_W-to-2^SEL_W decoder channels.
- Each channel runs in one of two modes:
  - direct mode: decodes the external select.
  - scan mode: an internal index cycles through all outputs with a programmable dwell time.
- Used for digit/row strobing (7-seg, LED matrix) in lab top-levels, replacing hand-wired dual decoders.

---
 rtl/dec_scan_pkg.sv | 20 ++
 rtl/dec_scan_chan.sv | 123 ++++++++++++
 rtl/dec_scan_nch.sv | 40 ++++
 tb/tb_dec_scan_nch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared constants and the active-low one-hot helper for the dec_scan_nch decoder family.
// Optional blanking feature is controlled by the DEC_SCAN_BLANK_EN macro (see dec_scan_chan).
package dec_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select supported by onehot_low; callers narrow the result with a size cast.
  localparam int unsigned MAX_SEL_W = 32'd8;

  function automatic logic [255:0] onehot_low(input logic [7:0] idx, input int unsigned width);
    logic [255:0] v;
    logic         in_range;
    v        = {256{1'b1}};
    in_range = (width <= MAX_SEL_W) && ({24'd0, idx} < (32'd1 << width));
    v[idx]   = ~in_range;
    return v;
  endfunction

endpackage

// File: rtl/dec_scan_chan.sv
// One decoder channel: index register, dwell counter and registered active-low outputs.
// With DEC_SCAN_BLANK_EN defined, each scan advance is preceded by one dark cycle.
module dec_scan_chan
  import dec_scan_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DIV_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    g_l,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DIV_W-1:0]        div,
  output logic [(2**SEL_W)-1:0]   y_l,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int          NOUT    = 2**SEL_W;
  localparam int unsigned SEL_WU  = SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

  logic [SEL_W-1:0] idx_r, idx_s, show_s;
  logic [DIV_W-1:0] dwell_r, dwell_s;
  logic [NOUT-1:0]  y_l_r, y_l_s, oh_s;
  logic             wrap_r, wrap_s, dark_s;
  logic [7:0]       idx_ext_s;
`ifdef DEC_SCAN_BLANK_EN
  logic             blank_r, blank_s;
`endif

  // Next-state decision: direct load, frozen, dwell count, (blank) or advance.
  always_comb begin
    idx_s   = idx_r;
    dwell_s = dwell_r;
    wrap_s  = 1'b0;
    show_s  = idx_r;
    dark_s  = 1'b1;
`ifdef DEC_SCAN_BLANK_EN
    blank_s = blank_r;
`endif
    case (mode)
      MODE_DIRECT: begin
        idx_s   = sel;
        dwell_s = {DIV_W{1'b0}};
        show_s  = sel;
        dark_s  = g_l;
`ifdef DEC_SCAN_BLANK_EN
        blank_s = 1'b0;
`endif
      end
      MODE_SCAN: begin
        if (g_l) begin
          dark_s = 1'b1;
`ifdef DEC_SCAN_BLANK_EN
        end else if (blank_r) begin
          idx_s   = idx_r + SEL_W'(1);
          dwell_s = {DIV_W{1'b0}};
          wrap_s  = (idx_r == IDX_MAX);
          blank_s = 1'b0;
          show_s  = idx_r + SEL_W'(1);
          dark_s  = 1'b0;
        end else if (dwell_r >= div) begin
          blank_s = 1'b1;
          dark_s  = 1'b1;
`else
        end else if (dwell_r >= div) begin
          idx_s   = idx_r + SEL_W'(1);
          dwell_s = {DIV_W{1'b0}};
          wrap_s  = (idx_r == IDX_MAX);
          show_s  = idx_r + SEL_W'(1);
          dark_s  = 1'b0;
`endif
        end else begin
          dwell_s = dwell_r + DIV_W'(1);
          dark_s  = 1'b0;
        end
      end
      default: begin
        dark_s = 1'b1;
      end
    endcase
  end

  // Output pattern for whatever index the register will hold (or dark).
  always_comb begin
    idx_ext_s              = 8'd0;
    idx_ext_s[SEL_W-1:0]   = show_s;
    oh_s                   = NOUT'(onehot_low(idx_ext_s, SEL_WU));
    if (dark_s) begin
      y_l_s = {NOUT{1'b1}};
    end else begin
      y_l_s = oh_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= {SEL_W{1'b0}};
      dwell_r <= {DIV_W{1'b0}};
      y_l_r   <= {NOUT{1'b1}};
      wrap_r  <= 1'b0;
`ifdef DEC_SCAN_BLANK_EN
      blank_r <= 1'b0;
`endif
    end else begin
      idx_r   <= idx_s;
      dwell_r <= dwell_s;
      y_l_r   <= y_l_s;
      wrap_r  <= wrap_s;
`ifdef DEC_SCAN_BLANK_EN
      blank_r <= blank_s;
`endif
    end
  end

  assign y_l  = y_l_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: rtl/dec_scan_nch.sv
// NCH independent registered active-low decoders with direct and scan modes.
// Optional pre-advance blanking is enabled by defining DEC_SCAN_BLANK_EN.
module dec_scan_nch
  import dec_scan_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int SEL_W = 2,
  parameter int DIV_W = 8
) (
  input  logic                         CLK,
  input  logic                         RESET_L,
  input  logic [NCH-1:0]               G_L,
  input  logic [NCH-1:0]               MODE,
  input  logic [NCH*SEL_W-1:0]         SEL,
  input  logic [DIV_W-1:0]             DIV,
  output logic [NCH*(2**SEL_W)-1:0]    Y_L,
  output logic [NCH*SEL_W-1:0]         IDX,
  output logic [NCH-1:0]               WRAP
);

  localparam int NOUT = 2**SEL_W;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    dec_scan_chan #(
      .SEL_W (SEL_W),
      .DIV_W (DIV_W)
    ) u_chan (
      .clk   (CLK),
      .rst_n (RESET_L),
      .g_l   (G_L[c]),
      .mode  (MODE[c]),
      .sel   (SEL[c*SEL_W +: SEL_W]),
      .div   (DIV),
      .y_l   (Y_L[c*NOUT +: NOUT]),
      .idx   (IDX[c*SEL_W +: SEL_W]),
      .wrap  (WRAP[c])
    );
  end

endmodule

// File: tb/tb_dec_scan_nch.sv
// Self-checking bench for dec_scan_nch (NCH=2, SEL_W=2, DIV_W=8) against an integer model.
module tb_dec_scan_nch;

`ifdef DEC_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic [1:0] G_L, MODE, WRAP;
  logic [3:0] SEL, IDX;
  logic [7:0] DIV, Y_L;

  int n_pass = 0;
  int n_checks = 0;

  // Model state: per-channel index, dwell count, pending-blank flag, plus expected outputs.
  int         m_idx[2];
  int         m_cnt[2];
  bit         m_blank[2];
  logic [7:0] e_y;
  logic [3:0] e_idx;
  logic [1:0] e_wrap;

  dec_scan_nch #(.NCH(2), .SEL_W(2), .DIV_W(8)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .G_L(G_L), .MODE(MODE), .SEL(SEL),
    .DIV(DIV), .Y_L(Y_L), .IDX(IDX), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_idx[c] = 0; m_cnt[c] = 0; m_blank[c] = 1'b0;
    end
    e_y = 8'hFF; e_idx = 4'h0; e_wrap = 2'b00;
  endtask

  function automatic logic [3:0] strobe(input int i);
    logic [3:0] v;
    v = 4'hF;
    v[i] = 1'b0;
    return v;
  endfunction

  // Advance the model one clock from the current inputs.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      int sel_c;
      bit dark;
      sel_c = int'(SEL[c*2 +: 2]);
      e_wrap[c] = 1'b0;
      dark = 1'b0;
      if (MODE[c] == 1'b0) begin
        m_idx[c] = sel_c; m_cnt[c] = 0; m_blank[c] = 1'b0;
        dark = G_L[c];
      end else if (G_L[c]) begin
        dark = 1'b1;
      end else if (m_blank[c] || (m_cnt[c] >= int'(DIV) && !BLANK)) begin
        m_idx[c] = (m_idx[c] + 1) % 4; m_cnt[c] = 0; m_blank[c] = 1'b0;
        e_wrap[c] = (m_idx[c] == 0);
      end else if (m_cnt[c] >= int'(DIV)) begin
        m_blank[c] = 1'b1;
        dark = 1'b1;
      end else begin
        m_cnt[c] = m_cnt[c] + 1;
      end
      e_idx[c*2 +: 2] = 2'(m_idx[c]);
      e_y[c*4 +: 4] = dark ? 4'hF : strobe(m_idx[c]);
    end
  endtask

  // One clock: update model, wait for the edge, compare all outputs.
  task automatic tick();
    if (RESET_L) model_step();
    @(posedge CLK);
    #1;
    check("Y_L", 32'(Y_L), 32'(e_y));
    check("IDX", 32'(IDX), 32'(e_idx));
    check("WRAP", 32'(WRAP), 32'(e_wrap));
  endtask

  logic [3:0] walk_y[5]   = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
  logic       walk_w[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int         prev_idx;
  int         budget;

  initial begin
    RESET_L = 1'b0; G_L = 2'b11; MODE = 2'b00; SEL = 4'h0; DIV = 8'd0;
    model_reset();
    tick(); tick();
    check("reset_y_l", 32'(Y_L), 32'h0000_00FF);
    check("reset_idx", 32'(IDX), 32'h0);
    RESET_L = 1'b1;
    tick();

    // Direct mode decode.
    G_L = 2'b00; SEL = {2'd2, 2'd1};
    tick();
    check("direct_y_l", 32'(Y_L), 32'h0000_00BD);
    check("direct_idx", 32'(IDX), 32'h9);
    G_L = 2'b10;
    tick();
    check("direct_disable_hi", 32'(Y_L[7:4]), 32'hF);

    // Scan ch0 from index 0 with DIV=0; ch1 stays direct at index 2.
    G_L = 2'b00; SEL = {2'd2, 2'd0};
    tick();
    MODE = 2'b01; DIV = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
`ifndef DEC_SCAN_BLANK_EN
      check("walk_y", 32'(Y_L[3:0]), 32'(walk_y[i]));
      check("walk_wrap", 32'(WRAP[0]), 32'(walk_w[i]));
`endif
    end

    // DIV=3 dwell with a 5-cycle disable mid-dwell.
    DIV = 8'd3;
    for (int i = 0; i < 6; i++) tick();
    G_L[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frozen_dark", 32'(Y_L[3:0]), 32'hF);
    end
    G_L[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // DIV lowered from 10 to 2 while dwell is 6.
    DIV = 8'd10;
    budget = 40;
    while (m_cnt[0] != 6 && budget > 0) begin
      tick();
      budget--;
    end
    check("dwell6_reached", 32'(budget > 0), 32'h1);
    prev_idx = m_idx[0];
    DIV = 8'd2;
    tick();
`ifndef DEC_SCAN_BLANK_EN
    check("div_drop_adv", 32'(IDX[1:0]), 32'((prev_idx + 1) % 4));
`endif
    for (int i = 0; i < 8; i++) tick();
    check("ch1_direct", 32'(Y_L[7:4]), 32'hB);

    // DIV=1 run (exercises the blanking period when enabled).
    DIV = 8'd1;
    for (int i = 0; i < 12; i++) tick();

    // Asynchronous reset mid-scan.
    #2;
    RESET_L = 1'b0;
    #1;
    check("async_reset_y_l", 32'(Y_L), 32'h0000_00FF);
    check("async_reset_wrap", 32'(WRAP), 32'h0);
    model_reset();
    tick();
    #2;
    RESET_L = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Back to direct on ch0: SEL overrides the scan index next cycle.
    MODE = 2'b00; SEL = {2'd1, 2'd3};
    tick();
    check("scan_to_direct", 32'(Y_L), 32'h0000_00D7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
